adler32_chk: RTL and testbench

Adler-32 trailer checker for the zlib/PNG decode path, the receive-side counterpart of `adler32`. It consumes the decompressed byte stream and computes Adler-32 (mod 65521). It takes the 4-byte big-endian trailer read from the zlib stream and reports the checksum together with a match/mismatch flag. It sits after the inflate core and before the unfilter stage.

---
 rtl/adler32_chk.sv | 143 ++++++++++++++
 tb/tb_adler32_chk.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adler32_chk.sv
// Adler-32 trailer checker: folds a byte stream into A/B (mod 65521) and compares {B,A} with the zlib trailer.
// Optional ADLER32_CHK_ERR_CNT_EN adds a saturating mismatch counter output err_cnt_o.
module adler32_chk #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned NUM_WD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic [NUM_WD-1:0]  num_i,
    input  logic               lst_i,
    input  logic               ref_val_i,
    input  logic [DATA_WD-1:0] ref_dat_i,
    output logic               rdy_o,
    output logic               done_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
`ifdef ADLER32_CHK_ERR_CNT_EN
    output logic [7:0]         err_cnt_o,
`endif
    output logic               ok_o
);

    localparam logic [16:0] MOD = 17'd65521;

    typedef enum logic [2:0] {IDLE, DAT, BYTE, WAIT_REF, OUT} state_t;

    state_t              state, state_n;
    logic [15:0]         a, b;
    logic [DATA_WD-1:0]  wbuf;
    logic [NUM_WD-1:0]   left;
    logic                last;
    logic                ref_flag;
    logic [DATA_WD-1:0]  ref_dat;

    logic                load, step, emit, rdy_n;
    logic [16:0]         a_sum, b_sum;
    logic [15:0]         a_nxt, b_nxt;

    // One Adler-32 byte step; 17-bit sums need at most one subtraction.
    always_comb begin
        a_sum = {1'b0, a} + 17'(wbuf[DATA_WD-1 -: 8]);
        a_nxt = (a_sum >= MOD) ? 16'(a_sum - MOD) : a_sum[15:0];
        b_sum = {1'b0, b} + {1'b0, a_nxt};
        b_nxt = (b_sum >= MOD) ? 16'(b_sum - MOD) : b_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        emit    = 1'b0;
        if (start_i) begin
            state_n = DAT;
        end else begin
            case (state)
                IDLE: ;
                DAT: begin
                    if (val_i) begin
                        state_n = BYTE;
                        load    = 1'b1;
                    end
                end
                BYTE: begin
                    step = 1'b1;
                    if (left == '0) state_n = last ? WAIT_REF : DAT;
                end
                WAIT_REF: begin
                    if (ref_flag) begin
                        state_n = OUT;
                        emit    = 1'b1;
                    end
                end
                OUT:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        rdy_n = (state_n == DAT);
    end

    // Datapath, trailer latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= 16'd1;
            b        <= 16'd0;
            wbuf     <= '0;
            left     <= '0;
            last     <= 1'b0;
            ref_flag <= 1'b0;
            ref_dat  <= '0;
            rdy_o    <= 1'b0;
            done_o   <= 1'b0;
            val_o    <= 1'b0;
            dat_o    <= '0;
            ok_o     <= 1'b0;
        end else begin
            rdy_o  <= rdy_n;
            val_o  <= emit;
            done_o <= emit;
            if (start_i) begin
                a        <= 16'd1;
                b        <= 16'd0;
                ref_flag <= 1'b0;
            end else begin
                if (ref_val_i && state != IDLE) begin
                    ref_flag <= 1'b1;
                    ref_dat  <= ref_dat_i;
                end
                if (load) begin
                    wbuf <= dat_i;
                    left <= num_i;
                    last <= lst_i;
                end
                if (step) begin
                    a    <= a_nxt;
                    b    <= b_nxt;
                    wbuf <= {wbuf[DATA_WD-9:0], 8'h00};
                    left <= left - NUM_WD'(1);
                end
                if (emit) begin
                    dat_o <= {b, a};
                    ok_o  <= ({b, a} == ref_dat);
                end
            end
        end
    end

`ifdef ADLER32_CHK_ERR_CNT_EN
    // Mismatch counter survives start_i; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          err_cnt_o <= 8'd0;
        else if (state == OUT && !ok_o && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_adler32_chk.sv
// Directed, table-driven bench for adler32_chk (with/without ADLER32_CHK_ERR_CNT_EN).
module tb_adler32_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, val_i, lst_i, ref_val_i;
    logic [31:0] dat_i, ref_dat_i;
    logic [1:0]  num_i;
    logic        rdy_o, done_o, val_o, ok_o;
    logic [31:0] dat_o;
`ifdef ADLER32_CHK_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    adler32_chk dut (
        .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
        .num_i(num_i), .lst_i(lst_i), .ref_val_i(ref_val_i), .ref_dat_i(ref_dat_i),
        .rdy_o(rdy_o), .done_o(done_o), .val_o(val_o), .dat_o(dat_o),
`ifdef ADLER32_CHK_ERR_CNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .ok_o(ok_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][1:0]  n;
        logic [2:0]       nw;
        logic             early;
        logic [31:0]      trl;
        logic [31:0]      exp_dat;
        logic             exp_ok;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int exp_err = 0;
    vec_t vecs [4];

    always @(negedge clk) if (done_o === 1'b1) done_total++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] w0, w1, w2, input logic [1:0] n0, n1, n2,
                                input logic [2:0] nw, input logic early, input logic [31:0] trl,
                                input logic [31:0] exp_dat, input logic exp_ok);
        vec_t v;
        v = '0;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.n[0] = n0; v.n[1] = n1; v.n[2] = n2;
        v.nw = nw; v.early = early; v.trl = trl;
        v.exp_dat = exp_dat; v.exp_ok = exp_ok;
        return v;
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic pulse_ref(input logic [31:0] v);
        ref_dat_i = v;
        ref_val_i = 1'b1;
        @(negedge clk);
        ref_val_i = 1'b0;
    endtask

    task automatic wait_rdy(input string name);
        int k = 0;
        while (rdy_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (rdy_o !== 1'b1) check({name, "_rdy_timeout"}, 64'(rdy_o), 64'd1);
    endtask

    // Accepts one word and checks rdy_o stays low for exactly n cycles.
    task automatic send_word(input logic [31:0] d, input logic [1:0] num, input logic lst);
        logic bad = 1'b0;
        wait_rdy("send");
        dat_i = d; num_i = num; lst_i = lst; val_i = 1'b1;
        @(negedge clk);
        val_i = 1'b0;
        for (int i = 0; i <= int'(num); i++) begin
            if (rdy_o !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("rdy_gap", {62'd0, bad, rdy_o}, {62'd0, 1'b0, ~lst});
    endtask

    task automatic get_result(input string name, input logic [31:0] exp_dat, input logic exp_ok, input int d0);
        int k = 0;
        while (val_o !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'd1);
        check({name, "_dat"}, 64'(dat_o), 64'(exp_dat));
        check({name, "_ok"}, 64'(ok_o), 64'(exp_ok));
        repeat (3) @(negedge clk);
        check({name, "_hold"}, {31'd0, val_o, dat_o}, {31'd0, 1'b0, exp_dat});
        check({name, "_done_cnt"}, 64'(done_total - d0), 64'd1);
        if (!exp_ok && exp_err < 255) exp_err++;
`ifdef ADLER32_CHK_ERR_CNT_EN
        check({name, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_err));
`endif
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int d0;
        v  = vecs[i];
        d0 = done_total;
        pulse_start();
        if (v.early) pulse_ref(v.trl);
        for (int w = 0; w < int'(v.nw); w++)
            send_word(v.w[w], v.n[w], (w == int'(v.nw) - 1));
        if (!v.early) pulse_ref(v.trl);
        get_result($sformatf("vec%0d", i), v.exp_dat, v.exp_ok, d0);
    endtask

    initial begin
        int d0;
        vecs[0] = mk(32'h61626300, 32'h0, 32'h0, 2'd2, 2'd0, 2'd0, 3'd1, 1'b0,
                     32'h024D0127, 32'h024D0127, 1'b1);
        vecs[1] = mk(32'h57696B69, 32'h70656469, 32'h61000000, 2'd3, 2'd3, 2'd0, 3'd3, 1'b1,
                     32'h11E60398, 32'h11E60398, 1'b1);
        vecs[2] = mk(32'h61626300, 32'h0, 32'h0, 2'd2, 2'd0, 2'd0, 3'd1, 1'b0,
                     32'h024D0128, 32'h024D0127, 1'b0);
        vecs[3] = mk(32'h57696B00, 32'h69706500, 32'h64696100, 2'd2, 2'd2, 2'd2, 3'd3, 1'b0,
                     32'h11E60398, 32'h11E60398, 1'b1);

        rst = 1'b1; start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0; ref_val_i = 1'b0;
        dat_i = '0; ref_dat_i = '0; num_i = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {27'd0, rdy_o, done_o, val_o, ok_o, dat_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Words and trailers offered in IDLE must be ignored.
        dat_i = 32'hFFFFFFFF; num_i = 2'd3; lst_i = 1'b1; val_i = 1'b1;
        ref_dat_i = 32'h00010001; ref_val_i = 1'b1;
        repeat (3) @(negedge clk);
        val_i = 1'b0; ref_val_i = 1'b0;
        check("idle_ignore", {61'd0, rdy_o, val_o, done_o}, 64'd0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // 257 bytes of 0xFF exercise both modulo reductions.
        d0 = done_total;
        pulse_start();
        pulse_ref(32'h080F000F);
        for (int i = 0; i < 64; i++) send_word(32'hFFFFFFFF, 2'd3, 1'b0);
        send_word(32'hFF000000, 2'd0, 1'b1);
        get_result("wrap", 32'h080F000F, 1'b1, d0);

        // Early trailer, then abort mid-word; the stale trailer must be dropped.
        d0 = done_total;
        pulse_start();
        pulse_ref(32'h024D0127);
        wait_rdy("abort");
        dat_i = 32'h57696B69; num_i = 2'd3; lst_i = 1'b0; val_i = 1'b1;
        @(negedge clk);
        val_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("abort_rdy", 64'(rdy_o), 64'd1);
        send_word(32'h00000000, 2'd0, 1'b1);
        repeat (4) @(negedge clk);
        check("abort_no_stale", {62'd0, val_o, done_o}, 64'd0);
        pulse_ref(32'h00010001);
        get_result("abort", 32'h00010001, 1'b1, d0);

        // Reset while bytes are being folded.
        pulse_start();
        wait_rdy("rst");
        dat_i = 32'h61626300; num_i = 2'd2; lst_i = 1'b1; val_i = 1'b1;
        @(negedge clk);
        val_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, rdy_o, done_o, val_o, ok_o, dat_o}, 64'd0);
`ifdef ADLER32_CHK_ERR_CNT_EN
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
`endif
        exp_err = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
